// File: rtl/psram_lbuf_rd_ctrl.sv
// rtl/psram_lbuf_rd_ctrl.sv - pSRAM line buffer read controller, ping-pong banks, 2-entry output FIFO
// Optional horizontal mirror: define PSRAM_LBUF_REVERSE_EN.
module psram_lbuf_rd_ctrl #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int LINE_WORDS = 480
) (
   input  logic          clkr,
   input  logic          rstnr,
   input  logic          line_req,
   output logic          busy,
   output logic          line_done,
   output logic          req_ovf,
   output logic [AW-1:0] ar,
   output logic          cer,
   input  logic [DW-1:0] qr,
   output logic [DW-1:0] pix_data,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic          pix_sol,
   output logic          pix_eol
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [AW-1:0] LW      = AW'(LINE_WORDS);
   localparam logic [AW-1:0] LW_LAST = AW'(LINE_WORDS - 1);
`ifdef PSRAM_LBUF_REVERSE_EN
   localparam logic [AW-2:0] OFF_START = (AW-1)'(LINE_WORDS - 1);
`else
   localparam logic [AW-2:0] OFF_START = '0;
`endif

   state_t          state;
   logic            bank;
   logic [AW-2:0]   offset;
   logic [AW-1:0]   rd_cnt;
   logic [AW-1:0]   out_cnt;
   logic            inflight;
   logic [DW-1:0]   fifo_mem [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      fifo_cnt;
   logic [DW-1:0]   head;
   logic [2:0]      occ;
   logic            pop;
   logic            last_acc;

   assign pix_valid = (fifo_cnt != 2'd0);
   assign pop       = pix_valid & pix_ready;
   assign last_acc  = pop && (out_cnt == LW_LAST);
   assign line_done = last_acc;
   assign busy      = (state != IDLE);
   assign pix_sol   = pix_valid && (out_cnt == '0);
   assign pix_eol   = pix_valid && (out_cnt == LW_LAST);
   assign ar        = {bank, offset};
   assign head      = fifo_mem[rd_ptr];

   // A word leaving the FIFO this cycle frees its slot, which keeps reads back-to-back.
   assign occ = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign cer = (state == READ) && (rd_cnt < LW) && (occ < 3'd2);

`ifdef PSRAM_LBUF_REVERSE_EN
   assign pix_data = {head[DW/2-1:0], head[DW-1:DW/2]};
`else
   assign pix_data = head;
`endif

   always_ff @(posedge clkr or negedge rstnr) begin
      if (!rstnr) begin
         state    <= IDLE;
         bank     <= 1'b0;
         offset   <= '0;
         rd_cnt   <= '0;
         out_cnt  <= '0;
         inflight <= 1'b0;
         req_ovf  <= 1'b0;
      end else begin
         inflight <= cer;
         if (line_req && busy && !last_acc)
            req_ovf <= 1'b1;
         case (state)
            IDLE: begin
               if (line_req) begin
                  state   <= READ;
                  rd_cnt  <= '0;
                  out_cnt <= '0;
                  offset  <= OFF_START;
               end
            end
            READ, DRAIN: begin
               if (cer) begin
                  rd_cnt <= rd_cnt + 1'b1;
`ifdef PSRAM_LBUF_REVERSE_EN
                  offset <= offset - 1'b1;
`else
                  offset <= offset + 1'b1;
`endif
               end
               if (pop)
                  out_cnt <= out_cnt + 1'b1;
               if (state == READ && rd_cnt == LW)
                  state <= DRAIN;
               // Back-to-back request: restart on the toggled bank without an idle cycle.
               if (last_acc) begin
                  bank <= ~bank;
                  if (line_req) begin
                     state   <= READ;
                     rd_cnt  <= '0;
                     out_cnt <= '0;
                     offset  <= OFF_START;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clkr or negedge rstnr) begin
      if (!rstnr) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_mem[wr_ptr] <= qr;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({inflight, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_lbuf_rd_ctrl.sv
// tb/tb_psram_lbuf_rd_ctrl.sv - scoreboard bench for psram_lbuf_rd_ctrl with a line-level reference model
// Honours PSRAM_LBUF_REVERSE_EN in the reference model.
module tb_psram_lbuf_rd_ctrl;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LW = 4;
`ifdef PSRAM_LBUF_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] d;
      logic        sol;
      logic        eol;
   } exp_t;

   typedef struct packed {
      logic [9:0] a;
      logic       first;
   } addr_t;

   logic          clkr;
   logic          rstnr;
   logic          line_req;
   logic          busy;
   logic          line_done;
   logic          req_ovf;
   logic [AW-1:0] ar;
   logic          cer;
   logic [DW-1:0] qr;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_sol;
   logic          pix_eol;

   psram_lbuf_rd_ctrl #(.AW(AW), .DW(DW), .LINE_WORDS(LW)) dut (
      .clkr      (clkr),
      .rstnr     (rstnr),
      .line_req  (line_req),
      .busy      (busy),
      .line_done (line_done),
      .req_ovf   (req_ovf),
      .ar        (ar),
      .cer       (cer),
      .qr        (qr),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_sol   (pix_sol),
      .pix_eol   (pix_eol)
   );

   logic [31:0] mem [1024];
   exp_t        exp_q[$];
   addr_t       addr_q[$];
   int          npass = 0;
   int          ntot = 0;
   int          cyc = 0;
   int          lines_open = 0;
   logic        m_bank = 1'b0;
   logic        exp_ovf = 1'b0;
   int          rmode = 0;
   int          req_cyc = 0;
   int          sol_cyc = 0;
   int          eol_cyc = 0;
   int          first_cer_cyc = 0;
   int          issued = 0;
   int          delivered = 0;
   int          max_out = 0;

   initial begin
      clkr = 1'b0;
      forever #5 clkr = ~clkr;
   end

   always @(posedge clkr) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      ntot++;
      if (act === expv) npass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
   endtask

   // Line buffer: registered read, data valid the cycle after cer.
   initial begin : ram_model
      logic       pend;
      logic [9:0] paddr;
      forever begin
         @(negedge clkr);
         pend  = cer;
         paddr = ar;
         @(posedge clkr);
         #1;
         if (pend) qr = mem[paddr];
      end
   end

   initial begin : ready_gen
      forever begin
         @(posedge clkr);
         #1;
         case (rmode)
            1:       pix_ready = ~pix_ready;
            2:       pix_ready = ($urandom_range(0, 3) != 0);
            default: pix_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clkr) begin : monitor
      addr_t a;
      exp_t  e;
      if (rstnr) begin
         if (issued - delivered > max_out) max_out = issued - delivered;
         if (cer) begin
            issued++;
            if (addr_q.size() == 0) chk("ar_unexpected_read", 64'(ar), 64'h3ff_dead);
            else begin
               a = addr_q.pop_front();
               chk("ar", 64'(ar), 64'(a.a));
               if (a.first) first_cer_cyc = cyc;
            end
         end
         if (pix_valid && pix_ready) begin
            delivered++;
            if (exp_q.size() == 0) chk("word_unexpected", 64'(pix_data), 64'hdead_0000_0000);
            else begin
               e = exp_q.pop_front();
               chk("word", {29'b0, pix_data, pix_sol, pix_eol, line_done},
                   {29'b0, e.d, e.sol, e.eol, e.eol});
               if (e.sol) sol_cyc = cyc;
               if (e.eol) begin
                  eol_cyc = cyc;
                  lines_open--;
               end
            end
         end else if (line_done) begin
            chk("line_done_without_transfer", 64'(line_done), 64'd0);
         end
      end
   end

   task automatic push_line();
      logic [8:0]  off;
      logic [9:0]  addr;
      logic [31:0] w;
      for (int i = 0; i < LW; i++) begin
         off  = REV ? 9'(LW - 1 - i) : 9'(i);
         addr = {m_bank, off};
         w    = mem[addr];
         if (REV) w = {w[15:0], w[31:16]};
         exp_q.push_back({w, (i == 0), (i == LW - 1)});
         addr_q.push_back({addr, (i == 0)});
      end
      m_bank = ~m_bank;
      lines_open++;
   endtask

   task automatic issue();
      @(posedge clkr);
      #1;
      line_req = 1'b1;
      req_cyc  = cyc;
      @(posedge clkr);
      #1;
      line_req = 1'b0;
      if (lines_open == 0) push_line();
      else exp_ovf = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(posedge clkr);
         #1;
         if (lines_open == 0 && exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_zero_outputs(input string name);
      chk(name, {15'b0, busy, line_done, req_ovf, ar, cer, pix_data, pix_valid, pix_sol, pix_eol}, 64'd0);
   endtask

   initial begin
      rstnr     = 1'b0;
      line_req  = 1'b0;
      qr        = '0;
      pix_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[3] = 32'hAAAA_BBBB;

      repeat (3) @(posedge clkr);
      #1;
      chk_zero_outputs("reset_state");
      rstnr = 1'b1;

      // Single line, full-rate drain
      issue();
      wait_idle("line1");
      chk("first_latency", 64'(sol_cyc - req_cyc), 64'd3);
      chk("line_throughput", 64'(eol_cyc - sol_cyc), 64'(LW - 1));
      chk("busy_after_line", 64'(busy), 64'd0);

      // Ping-pong across banks
      issue();
      wait_idle("bank1");
      issue();
      wait_idle("bank0_again");

      // Request on the cycle of the last accepted word
      issue();
      repeat (4) @(posedge clkr);
      issue();
      chk("backtoback_busy", 64'(busy), 64'd1);
      @(negedge clkr);
      #1;
      chk("backtoback_no_gap", 64'(first_cer_cyc - eol_cyc), 64'd1);
      wait_idle("backtoback");
      chk("backtoback_ovf", 64'(req_ovf), 64'(exp_ovf));

      // Stalled downstream: alternating then random ready
      for (int m = 1; m <= 2; m++) begin
         rmode = m;
         for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clkr);
            issue();
            wait_idle("stall");
         end
      end
      rmode = 0;
      chk("fifo_bound", 64'(max_out > 3), 64'd0);
      chk("ovf_clear_before_overlap", 64'(req_ovf), 64'd0);

      // Request while busy is dropped and flagged
      issue();
      issue();
      chk("ovf_set", 64'(req_ovf), 64'(exp_ovf));
      wait_idle("overlap");
      chk("ovf_sticky", 64'(req_ovf), 64'(exp_ovf));

      // Reset in the middle of a line
      issue();
      repeat (4) @(posedge clkr);
      #3;
      rstnr = 1'b0;
      #1;
      chk_zero_outputs("midline_reset");
      exp_q.delete();
      addr_q.delete();
      lines_open = 0;
      m_bank     = 1'b0;
      exp_ovf    = 1'b0;
      issued     = 0;
      delivered  = 0;
      @(posedge clkr);
      #1;
      rstnr = 1'b1;
      issue();
      wait_idle("after_reset");
      chk("after_reset_ovf", 64'(req_ovf), 64'd0);
      chk("after_reset_bank", 64'(m_bank), 64'd1);

      repeat (3) @(posedge clkr);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
